// File: rtl/des_dec_key_sched.sv
// DES decryption key schedule.
// Emits the 16 round keys in reverse order K16..K1, one per valid/ready
// handshake. C/D are loaded with PC-1(key) and rotated right between rounds.
// The subkey output is PC-2 of the C/D registers.
module des_dec_key_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] key,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        last
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Permutation tables use 1-based bit numbers with bit 1 = MSB.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  round_q, round_d;

  logic [55:0] pc1_key;
  logic [55:0] cd_q;
  logic        one_shift;

  // PC-1: pure wiring. Bit p (1-based, MSB first) sits at vector index 64-p.
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_key[55-i] = key[64-PC1[i]];
  end

  // PC-2 straight off the C/D registers, so there is no path from key.
  assign cd_q = {c_q, d_q};
  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign subkey[47-j] = cd_q[56-PC2[j]];
  end

  // Reverse of the forward shift table: rounds 0, 7 and 14 rotate by one.
  assign one_shift = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);

  // Next-state logic: key load in IDLE, rotate/advance on each handshake in RUN.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d = RUN;
          c_d     = pc1_key[55:28];
          d_d     = pc1_key[27:0];
          round_d = 4'd0;
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (round_q == 4'd15) begin
            // C/D keep K1 so the subkey output holds the last emitted key.
            state_d = IDLE;
            round_d = 4'd0;
          end else begin
            round_d = round_q + 4'd1;
            if (one_shift) begin
              c_d = {c_q[0], c_q[27:1]};
              d_d = {d_q[0], d_q[27:1]};
            end else begin
              c_d = {c_q[1:0], c_q[27:2]};
              d_d = {d_q[1:0], d_q[27:2]};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset, which overrides any handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
    end
  end

  assign key_ready    = (state_q == IDLE);
  assign subkey_valid = (state_q == RUN);
  assign round_idx    = round_q;
  assign last         = (state_q == RUN) && (round_q == 4'd15);

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Testbench for des_dec_key_sched: a reference model computes the forward
// FIPS key schedule and queues K16..K1; a monitor pops and compares on
// every handshake.
module tb_des_dec_key_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] key;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        last;

  des_dec_key_sched dut (
    .clk          (clk),
    .reset        (reset),
    .key          (key),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .last         (last)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] VEC_KEY = 64'h133457799BBCDFF1;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  idx;
  } exp_t;

  exp_t        sb[$];
  logic [47:0] model_k [1:16];
  int          vectors    = 0;
  int          miscompares = 0;
  int          emitted    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Forward FIPS 46-3 schedule: K1..K16 via left rotations of C and D.
  task automatic model_schedule(input logic [63:0] k);
    bit          kb [1:64];
    bit          c  [1:28];
    bit          d  [1:28];
    bit          cd [1:56];
    bit          t;
    logic [63:0] kk;
    logic [47:0] ks;
    kk = k;
    for (int i = 1; i <= 64; i++) begin
      kb[i] = kk[63];
      kk    = kk << 1;
    end
    for (int i = 1; i <= 28; i++) begin
      c[i] = kb[PC1_T[i-1]];
      d[i] = kb[PC1_T[i+27]];
    end
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < SHIFT_T[r-1]; s++) begin
        t = c[1];
        for (int j = 1; j < 28; j++) c[j] = c[j+1];
        c[28] = t;
        t = d[1];
        for (int j = 1; j < 28; j++) d[j] = d[j+1];
        d[28] = t;
      end
      for (int j = 1; j <= 28; j++) begin
        cd[j]    = c[j];
        cd[j+28] = d[j];
      end
      ks = '0;
      for (int j = 1; j <= 48; j++) ks = {ks[46:0], cd[PC2_T[j-1]]};
      model_k[r] = ks;
    end
  endtask

  // Decryption order: round_idx n carries K(16-n).
  task automatic push_expected(input logic [63:0] k);
    model_schedule(k);
    for (int r = 16; r >= 1; r--) sb.push_back('{sk: model_k[r], idx: 4'(16 - r)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Present a key until accepted; returns one cycle after the accepting edge.
  task automatic load_key(input logic [63:0] k);
    int b = 0;
    key       = k;
    key_valid = 1'b1;
    while (!key_ready && b < 100) begin
      tick();
      b++;
    end
    if (b >= 100) check("key_ready_timeout", 64'(key_ready), 64'd1);
    push_expected(k);
    tick();
    key_valid = 1'b0;
    key       = rand64();
  endtask

  task automatic wait_idle();
    int b = 0;
    while (!key_ready && b < 400) begin
      tick();
      b++;
    end
    if (b >= 400) check("idle_timeout", 64'(key_ready), 64'd1);
  endtask

  task automatic wait_round(input logic [3:0] n);
    int b = 0;
    while (round_idx != n && b < 100) begin
      tick();
      b++;
    end
    if (b >= 100) check("round_timeout", 64'(round_idx), 64'(n));
  endtask

  // Random backpressure plus key noise that must be ignored while in RUN.
  task automatic run_random();
    int b = 0;
    while (!key_ready && b < 400) begin
      subkey_ready = ($urandom_range(0, 3) != 0);
      key          = rand64();
      key_valid    = ($urandom_range(0, 2) == 0);
      tick();
      b++;
    end
    key_valid = 1'b0;
    if (b >= 400) check("random_timeout", 64'(key_ready), 64'd1);
  endtask

  // Monitor: every handshake consumes one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && subkey_valid && subkey_ready) begin
        emitted++;
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("subkey", 64'(subkey), 64'(e.sk));
          check("round_idx", 64'(round_idx), 64'(e.idx));
          check("last", 64'(last), 64'(e.idx == 4'd15));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    logic [47:0] held;
    reset        = 1'b1;
    key          = '0;
    key_valid    = 1'b0;
    subkey_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_key_ready", 64'(key_ready), 64'd1);
    check("rst_subkey_valid", 64'(subkey_valid), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    check("rst_round_idx", 64'(round_idx), 64'd0);
    check("rst_last", 64'(last), 64'd0);

    // Known-answer vector with subkey_ready held high
    base = emitted;
    load_key(VEC_KEY);
    check("kat_k16", 64'(subkey), 64'h0000CB3D8B0E17F5);
    check("kat_idx0", 64'(round_idx), 64'd0);
    repeat (14) tick();
    check("kat_idx14", 64'(round_idx), 64'd14);
    check("kat_k2", 64'(subkey), 64'h000079AED9DBC9E5);
    tick();
    check("kat_k1", 64'(subkey), 64'h00001B02EFFC7072);
    check("kat_last", 64'(last), 64'd1);
    tick();
    check("kat_key_ready", 64'(key_ready), 64'd1);
    check("kat_valid_low", 64'(subkey_valid), 64'd0);
    check("kat_hold_k1", 64'(subkey), 64'h00001B02EFFC7072);
    check("kat_idle_last", 64'(last), 64'd0);
    check("kat_idle_idx", 64'(round_idx), 64'd0);
    check("kat_count", 64'(emitted - base), 64'd16);

    // All-zero, all-one and parity-only keys
    base = emitted;
    load_key(64'h0000000000000000);
    wait_idle();
    load_key(64'hFFFFFFFFFFFFFFFF);
    wait_idle();
    check("ones_hold", 64'(subkey), 64'h0000FFFFFFFFFFFF);
    load_key(64'h0101010101010101);
    wait_idle();
    check("parity_hold", 64'(subkey), 64'd0);
    check("edge_count", 64'(emitted - base), 64'd48);

    // Backpressure for 3 cycles at round_idx 5
    base = emitted;
    load_key(VEC_KEY);
    wait_round(4'd5);
    subkey_ready = 1'b0;
    held = subkey;
    check("stall_k11", 64'(held), 64'(model_k[11]));
    repeat (3) begin
      tick();
      check("stall_subkey", 64'(subkey), 64'(held));
      check("stall_idx", 64'(round_idx), 64'd5);
      check("stall_valid", 64'(subkey_valid), 64'd1);
    end
    subkey_ready = 1'b1;
    wait_idle();
    check("stall_count", 64'(emitted - base), 64'd16);

    // key_valid held through the final handshake
    base = emitted;
    load_key(VEC_KEY);
    wait_round(4'd15);
    key       = 64'h0E329232EA6D0D73;
    key_valid = 1'b1;
    tick();
    check("b2b_key_ready", 64'(key_ready), 64'd1);
    check("b2b_valid_low", 64'(subkey_valid), 64'd0);
    push_expected(64'h0E329232EA6D0D73);
    tick();
    key_valid = 1'b0;
    check("b2b_valid", 64'(subkey_valid), 64'd1);
    check("b2b_idx", 64'(round_idx), 64'd0);
    check("b2b_k16", 64'(subkey), 64'(model_k[16]));
    wait_idle();
    check("b2b_count", 64'(emitted - base), 64'd32);

    // Reset mid-sequence at round_idx 7
    load_key(VEC_KEY);
    wait_round(4'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("mid_rst_valid", 64'(subkey_valid), 64'd0);
    check("mid_rst_subkey", 64'(subkey), 64'd0);
    check("mid_rst_key_ready", 64'(key_ready), 64'd1);
    check("mid_rst_idx", 64'(round_idx), 64'd0);
    load_key(VEC_KEY);
    check("mid_rst_k16", 64'(subkey), 64'h0000CB3D8B0E17F5);
    wait_idle();

    // Random keys, random backpressure, ignored key noise in RUN
    for (int n = 0; n < 8; n++) begin
      base = emitted;
      subkey_ready = ($urandom_range(0, 1) != 0);
      load_key(rand64());
      run_random();
      check("rand_count", 64'(emitted - base), 64'd16);
      subkey_ready = 1'b1;
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
